volume_meter: RTL

Downstream consumer of the 2048-sample average-volume stage. Takes one 0–100 volume value per frame and turns it into a stable bar-graph display level for the board LEDs / seven-segment driver. Provides instant attack with timed release, optional peak-hold with per-frame fall-off, and a clip indicator latched for a fixed number of frames.

---
 rtl/volume_meter_pkg.sv | 21 ++
 rtl/volume_quantizer.sv | 26 ++
 rtl/volume_meter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/volume_meter_pkg.sv
// Shared types and constants for the volume meter: FSM states, value ranges and widths.
package volume_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_OUT
  } state_e;

  localparam int unsigned SMOOTH_W  = 7;
  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned BAR_W     = 10;
  localparam logic [6:0]  VOL_MAX   = 7'd100;
  localparam logic [3:0]  LEVEL_MAX = 4'd10;

  // Clamp an 8-bit input volume to the nominal 0..100 range.
  function automatic logic [6:0] sat_volume(input logic [7:0] v);
    return (v > {1'b0, VOL_MAX}) ? VOL_MAX : v[6:0];
  endfunction

endpackage

// File: rtl/volume_quantizer.sv
// Combinational 7-bit to display-level converter: saturating divide by 10 and
// thermometer encoding of the result.
module volume_quantizer
  import volume_meter_pkg::*;
(
  input  logic [SMOOTH_W-1:0] value_i,
  output logic [LEVEL_W-1:0]  level_o,
  output logic [BAR_W-1:0]    bar_o
);

  logic [SMOOTH_W-1:0] quot;

  always_comb begin
    quot = value_i / 7'd10;
    if (quot > {3'b000, LEVEL_MAX}) begin
      level_o = LEVEL_MAX;
    end else begin
      level_o = quot[LEVEL_W-1:0];
    end
    bar_o = '0;
    for (int i = 0; i < BAR_W; i++) begin
      bar_o[i] = (level_o > 4'(i));
    end
  end

endmodule

// File: rtl/volume_meter.sv
// Per-frame volume to bar-graph level with instant attack, timed release and clip latch.
// Optional peak-hold is enabled by defining VOLUME_METER_PEAK_EN.
module volume_meter
  import volume_meter_pkg::*;
#(
  parameter int unsigned DECAY_CYCLES = 1_200_000,
  parameter int unsigned DECAY_STEP   = 5,
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter int unsigned CLIP_THR     = 90,
  parameter int unsigned CLIP_FRAMES  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               in_valid,
  input  logic [7:0]         in_volume,
  output logic               o_valid,
  output logic [LEVEL_W-1:0] o_level,
  output logic [BAR_W-1:0]   o_bar,
  output logic [LEVEL_W-1:0] o_peak,
  output logic               o_clip,
  output logic               o_drop
);

  if (DECAY_CYCLES < 1 || DECAY_STEP > 100 || HOLD_FRAMES > 255 || CLIP_FRAMES > 255)
  begin : g_param_check
    $error("volume_meter: parameter out of range");
  end

  localparam int unsigned TickW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [TickW-1:0]    TickLast = TickW'(DECAY_CYCLES - 1);
  localparam logic [SMOOTH_W-1:0] Step     = SMOOTH_W'(DECAY_STEP);
  localparam logic [7:0]          ClipInit = 8'(CLIP_FRAMES);

  state_e              state_q, state_d;
  logic [SMOOTH_W-1:0] vol_q, vol_d;
  logic [SMOOTH_W-1:0] smooth_q, smooth_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [7:0]          clip_cnt_q, clip_cnt_d;
  logic [LEVEL_W-1:0]  level_q;
  logic [BAR_W-1:0]    bar_q;
  logic                valid_q;
  logic                drop_q, drop_d;
  logic                tick;
  logic                update;
  logic [LEVEL_W-1:0]  q_level;
  logic [BAR_W-1:0]    q_bar;

  always_comb begin
    state_d    = state_q;
    vol_d      = vol_q;
    smooth_d   = smooth_q;
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    update     = (state_q == S_UPDATE);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          vol_d   = sat_volume(in_volume);
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_OUT;
      S_OUT:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A frame update takes priority over a coincident release tick.
    if (update) begin
      smooth_d = (vol_q > smooth_q) ? vol_q : smooth_q;
    end else if (tick) begin
      smooth_d = (32'(smooth_q) >= DECAY_STEP) ? smooth_q - Step : '0;
    end

    clip_cnt_d = clip_cnt_q;
    if (update) begin
      if (32'(vol_q) >= CLIP_THR) begin
        clip_cnt_d = ClipInit;
      end else if (clip_cnt_q != '0) begin
        clip_cnt_d = clip_cnt_q - 8'd1;
      end
    end

    drop_d = drop_q | (in_valid && (state_q != S_IDLE));
  end

  // Display level always tracks the next smoothed value so ticks and updates share one path.
  volume_quantizer u_quant (
    .value_i (smooth_d),
    .level_o (q_level),
    .bar_o   (q_bar)
  );

`ifdef VOLUME_METER_PEAK_EN
  localparam logic [7:0] HoldInit = 8'(HOLD_FRAMES);

  logic [LEVEL_W-1:0] peak_q, peak_d;
  logic [7:0]         hold_q, hold_d;

  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (update) begin
      if (q_level >= peak_q) begin
        peak_d = q_level;
        hold_d = HoldInit;
      end else if (hold_q != '0) begin
        hold_d = hold_q - 8'd1;
      end else if (peak_q != '0) begin
        peak_d = peak_q - 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign o_peak = peak_q;
`else
  assign o_peak = level_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      vol_q      <= '0;
      smooth_q   <= '0;
      tick_cnt_q <= '0;
      clip_cnt_q <= '0;
      level_q    <= '0;
      bar_q      <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vol_q      <= vol_d;
      smooth_q   <= smooth_d;
      tick_cnt_q <= tick_cnt_d;
      clip_cnt_q <= clip_cnt_d;
      level_q    <= q_level;
      bar_q      <= q_bar;
      valid_q    <= update;
      drop_q     <= drop_d;
    end
  end

  assign o_valid = valid_q;
  assign o_level = level_q;
  assign o_bar   = bar_q;
  assign o_clip  = (clip_cnt_q != '0);
  assign o_drop  = drop_q;

endmodule
